mux_scan_ctrl: RTL

MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

---
 rtl/mux_scan_pkg.sv | 21 ++
 rtl/mux_scan_pick.sv | 22 ++
 rtl/mux_scan_ctrl.sv | 119 +++++++++++
 3 files changed

// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the mux scan controller.
package mux_scan_pkg;

  localparam int NCH   = 8;
  localparam int SEL_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEL  = 2'd1,
    PRES = 2'd2
  } state_t;

  // Index of the lowest set bit; 0 when no bit is set (callers qualify with |m).
  function automatic logic [SEL_W-1:0] lowest_set(input logic [NCH-1:0] m);
    lowest_set = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (m[i]) lowest_set = SEL_W'(i);
    end
  endfunction

endpackage

// File: rtl/mux_scan_pick.sv
// Combinational next-channel search: next enabled channel above cur, plus the lowest enabled one.
module mux_scan_pick
  import mux_scan_pkg::*;
(
  input  logic [NCH-1:0]   mask,
  input  logic [SEL_W-1:0] cur,
  output logic [SEL_W-1:0] nxt,
  output logic             found,
  output logic [SEL_W-1:0] lowest
);

  logic [NCH-1:0] above;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_above
    assign above[gi] = mask[gi] && (gi > int'(cur));
  end

  assign found  = |above;
  assign nxt    = lowest_set(above);
  assign lowest = lowest_set(mask);

endmodule

// File: rtl/mux_scan_ctrl.sv
// Sweeps the select of an external 8:1 mux and streams captured samples with a valid/ready handshake.
// Optional MUX_SCAN_PARITY_EN adds out_par, the XOR of out_data registered alongside it.
module mux_scan_ctrl #(
  parameter int WIDTH = 3,
  parameter int NCH   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             cont,
  input  logic [NCH-1:0]   ch_mask,
  output logic [2:0]       sel,
  input  logic [WIDTH-1:0] mux_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [2:0]       out_ch,
  output logic             busy,
  output logic             done
`ifdef MUX_SCAN_PARITY_EN
  ,
  output logic             out_par
`endif
);
  import mux_scan_pkg::*;

  state_t         state_reg;
  logic [NCH-1:0] mask_reg;
  logic           cont_reg;

  logic [SEL_W-1:0] pick_next;
  logic [SEL_W-1:0] pick_lowest;
  logic             pick_found;

  mux_scan_pick u_pick (
    .mask   (mask_reg),
    .cur    (sel),
    .nxt    (pick_next),
    .found  (pick_found),
    .lowest (pick_lowest)
  );

  assign busy = (state_reg != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      mask_reg  <= '0;
      cont_reg  <= 1'b0;
      sel       <= '0;
      out_data  <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start && !stop) begin
            mask_reg <= ch_mask;
            cont_reg <= cont;
            if (|ch_mask) begin
              sel       <= lowest_set(ch_mask);
              state_reg <= SEL;
            end else begin
              done <= 1'b1;
            end
          end
        end
        SEL: begin
          if (stop) begin
            out_valid <= 1'b0;
            state_reg <= IDLE;
          end else begin
            out_data  <= mux_data;
            out_ch    <= sel;
            out_valid <= 1'b1;
            state_reg <= PRES;
          end
        end
        PRES: begin
          // stop outranks a simultaneous handshake: the sample is dropped, no done.
          if (stop) begin
            out_valid <= 1'b0;
            state_reg <= IDLE;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            if (pick_found) begin
              sel       <= pick_next;
              state_reg <= SEL;
            end else if (cont_reg) begin
              sel       <= pick_lowest;
              state_reg <= SEL;
            end else begin
              done      <= 1'b1;
              state_reg <= IDLE;
            end
          end
        end
        default: begin
          out_valid <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

`ifdef MUX_SCAN_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_par <= 1'b0;
    end else if (state_reg == SEL && !stop) begin
      out_par <= ^mux_data;
    end
  end
`endif

endmodule
